// File: rtl/mul_grp_acc.sv
// mul_grp_acc: three-stage multiply and group-sum block.
// Stage 0 captures an operand pair. Stage 1 forms the full-width product.
// Stage 2 adds GRP consecutive products and publishes each finished group
// on dout, with a one-cycle dout_en pulse.
// Operand registers load only on accepted samples, so the multiplier inputs
// stay still while the stream is idle.
module mul_grp_acc #(
  parameter int W      = 4,
  parameter int GRP    = 2,
  parameter int SIGNED = 0,
  localparam int OW    = 2*W + $clog2(GRP)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          en,
  input  logic          clr,
  input  logic [W-1:0]  mul1,
  input  logic [W-1:0]  mul2,
  output logic          dout_en,
  output logic [OW-1:0] dout,
  output logic          partial
);

  // Group index width; kept at least one bit so GRP=1 still has a legal vector.
  localparam int IDXW = (GRP > 1) ? $clog2(GRP) : 1;
  localparam int PW   = 2*W;

  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(GRP - 1);
  localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(1);

  // ---------------------------------------------------------------------
  // Stage 0: operand capture
  // ---------------------------------------------------------------------
  logic [W-1:0] op1_q, op2_q;
  logic         v0_q;
  logic         accept;

  // clr wins over a same-cycle en, and that sample is dropped.
  assign accept = en & ~clr;

  // Operand registers load only on an accepted sample.
  // Their values are therefore never disturbed by don't-care inputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      op1_q <= '0;
      op2_q <= '0;
    end else if (accept) begin
      op1_q <= mul1;
      op2_q <= mul2;
    end
  end

  // Stage-0 valid: marks a freshly captured pair.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) v0_q <= 1'b0;
    else       v0_q <= accept;
  end

  // ---------------------------------------------------------------------
  // Stage 1: multiply
  // ---------------------------------------------------------------------
  logic [PW-1:0] op1_ext, op2_ext, prod_d, prod_q;
  logic          op1_sx, op2_sx;
  logic          v1_q;

  // Sign bits used for extension; forced to zero in unsigned mode.
  assign op1_sx = (SIGNED != 0) & op1_q[W-1];
  assign op2_sx = (SIGNED != 0) & op2_q[W-1];

  // Extend both operands to 2W first. The low 2W bits of the product are
  // then exact for both signed and unsigned operands.
  assign op1_ext = {{W{op1_sx}}, op1_q};
  assign op2_ext = {{W{op2_sx}}, op2_q};
  assign prod_d  = op1_ext * op2_ext;

  // Product register loads only behind a valid stage-0 entry.
  // Otherwise it holds, so the adder inputs stay quiet.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      prod_q <= '0;
    end else if (v0_q && !clr) begin
      prod_q <= prod_d;
    end
  end

  // Stage-1 valid: follows stage 0 unless the pipeline is being flushed.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) v1_q <= 1'b0;
    else       v1_q <= v0_q & ~clr;
  end

  // ---------------------------------------------------------------------
  // Stage 2: group accumulation
  // ---------------------------------------------------------------------
  logic [OW-1:0]   prod_ext;
  logic [OW-1:0]   sum;
  logic [OW-1:0]   acc_q, acc_d;
  logic [OW-1:0]   dout_q, dout_d;
  logic            dout_en_q, dout_en_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            prod_sx;
  logic            last;

  assign prod_sx = (SIGNED != 0) & prod_q[PW-1];

  // Widen the product to the result width.
  // The widths already match when GRP=1.
  generate
    if (OW > PW) begin : g_ext
      assign prod_ext = {{(OW-PW){prod_sx}}, prod_q};
    end else begin : g_noext
      assign prod_ext = prod_q;
    end
  endgenerate

  // The first element of a group replaces the stale accumulator value.
  assign sum  = (idx_q == '0) ? prod_ext : (acc_q + prod_ext);
  assign last = (idx_q == IDX_LAST);

  // Next-state logic for the accumulator, index and result.
  // Defaults hold state and keep the result pulse low.
  always_comb begin
    acc_d     = acc_q;
    idx_d     = idx_q;
    dout_d    = dout_q;
    dout_en_d = 1'b0;
    if (clr) begin
      acc_d = '0;
      idx_d = '0;
    end else if (v1_q) begin
      acc_d = sum;
      if (last) begin
        dout_d    = sum;
        dout_en_d = 1'b1;
        idx_d     = '0;
      end else begin
        idx_d = idx_q + IDX_ONE;
      end
    end
  end

  // Stage-2 state register.
  // dout keeps the last completed group across idle cycles and clr.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_q     <= '0;
      idx_q     <= '0;
      dout_q    <= '0;
      dout_en_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      idx_q     <= idx_d;
      dout_q    <= dout_d;
      dout_en_q <= dout_en_d;
    end
  end

  assign dout    = dout_q;
  assign dout_en = dout_en_q;

  // A group is in progress if it has accumulated elements or anything is in flight.
  assign partial = (idx_q != '0) | v0_q | v1_q;

endmodule

// File: tb/tb_mul_grp_acc.sv
// tb_mul_grp_acc: drives five configurations of mul_grp_acc from one shared
// stimulus stream. Every cycle, each configuration is compared with an
// event-level reference model. The model keeps a queue of accepted samples
// and a per-configuration running group sum.
module tb_mul_grp_acc;

  localparam int NC = 5;
  localparam int GRP_C [NC] = '{2, 4, 2, 3, 1};
  localparam int SGN_C [NC] = '{0, 0, 1, 0, 1};
  localparam int OW_C  [NC] = '{9, 10, 9, 10, 8};

  logic       clk = 1'b0;
  logic       rstn;
  logic       en, clr;
  logic [3:0] mul1, mul2;

  logic [8:0] d0;
  logic [9:0] d1;
  logic [8:0] d2;
  logic [9:0] d3;
  logic [7:0] d4;
  logic       den [NC];
  logic       par [NC];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mul_grp_acc #(.W(4), .GRP(2), .SIGNED(0)) u0 (.clk(clk), .rstn(rstn), .en(en), .clr(clr),
    .mul1(mul1), .mul2(mul2), .dout_en(den[0]), .dout(d0), .partial(par[0]));
  mul_grp_acc #(.W(4), .GRP(4), .SIGNED(0)) u1 (.clk(clk), .rstn(rstn), .en(en), .clr(clr),
    .mul1(mul1), .mul2(mul2), .dout_en(den[1]), .dout(d1), .partial(par[1]));
  mul_grp_acc #(.W(4), .GRP(2), .SIGNED(1)) u2 (.clk(clk), .rstn(rstn), .en(en), .clr(clr),
    .mul1(mul1), .mul2(mul2), .dout_en(den[2]), .dout(d2), .partial(par[2]));
  mul_grp_acc #(.W(4), .GRP(3), .SIGNED(0)) u3 (.clk(clk), .rstn(rstn), .en(en), .clr(clr),
    .mul1(mul1), .mul2(mul2), .dout_en(den[3]), .dout(d3), .partial(par[3]));
  mul_grp_acc #(.W(4), .GRP(1), .SIGNED(1)) u4 (.clk(clk), .rstn(rstn), .en(en), .clr(clr),
    .mul1(mul1), .mul2(mul2), .dout_en(den[4]), .dout(d4), .partial(par[4]));

  // ---------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------
  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    int         due;   // edge number at which this element joins its group
  } pend_t;

  pend_t pq[$];
  int    edge_n;
  int    gsum  [NC];
  int    gcnt  [NC];
  int    dout_m[NC];
  bit    den_m [NC];

  function automatic int as_int(int c, logic [3:0] v);
    if (SGN_C[c] != 0 && v[3]) return int'(v) - 16;
    return int'(v);
  endfunction

  task automatic model_reset();
    pq.delete();
    edge_n = 0;
    for (int c = 0; c < NC; c++) begin
      gsum[c] = 0; gcnt[c] = 0; dout_m[c] = 0; den_m[c] = 0;
    end
  endtask

  task automatic model_edge();
    pend_t p;
    edge_n++;
    for (int c = 0; c < NC; c++) den_m[c] = 0;
    if (clr) begin
      // Everything not yet merged into a finished group is discarded.
      pq.delete();
      for (int c = 0; c < NC; c++) begin gsum[c] = 0; gcnt[c] = 0; end
    end else if (pq.size() > 0 && pq[0].due == edge_n) begin
      p = pq.pop_front();
      for (int c = 0; c < NC; c++) begin
        gsum[c] += as_int(c, p.a) * as_int(c, p.b);
        gcnt[c]++;
        if (gcnt[c] == GRP_C[c]) begin
          dout_m[c] = gsum[c];
          den_m[c]  = 1;
          gsum[c]   = 0;
          gcnt[c]   = 0;
        end
      end
    end
    if (en && !clr) begin
      p.a = mul1; p.b = mul2; p.due = edge_n + 2;
      pq.push_back(p);
    end
  endtask

  // Model tracks every rising edge and the asynchronous reset.
  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rstn);
      if (!rstn) model_reset();
      else       model_edge();
    end
  end

  // ---------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------
  task automatic check_eq(string tag, logic [15:0] got, logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] get_dout(int c);
    case (c)
      0: return 16'(d0);
      1: return 16'(d1);
      2: return 16'(d2);
      3: return 16'(d3);
      default: return 16'(d4);
    endcase
  endfunction

  task automatic check_all(string tag);
    logic [15:0] exp;
    for (int c = 0; c < NC; c++) begin
      exp = 16'(dout_m[c] & ((1 << OW_C[c]) - 1));
      check_eq($sformatf("%s_c%0d_dout", tag, c), get_dout(c), exp);
      check_eq($sformatf("%s_c%0d_den", tag, c), 16'(den[c]), 16'(den_m[c]));
      check_eq($sformatf("%s_c%0d_partial", tag, c), 16'(par[c]),
               16'((gcnt[c] != 0 || pq.size() != 0) ? 1 : 0));
    end
  endtask

  // ---------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------
  task automatic step(bit e, bit c, logic [3:0] a, logic [3:0] b);
    @(negedge clk);
    en = e; clr = c; mul1 = a; mul2 = b;
    @(posedge clk);
    #1;
    check_all("cyc");
    $display("cyc t=%0t en=%0b clr=%0b a=%0d b=%0d den=%0b%0b%0b%0b%0b", $time, e, c, a, b,
             den[0], den[1], den[2], den[3], den[4]);
  endtask

  task automatic idle(int n);
    repeat (n) step(1'b0, 1'b0, 4'($urandom), 4'($urandom));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0; en = 1'b0; clr = 1'b0;
    #1;
    check_all("rst");
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    int r;
    rstn = 1'b0; en = 1'b0; clr = 1'b0; mul1 = '0; mul2 = '0;
    repeat (2) @(posedge clk);
    #1;
    check_all("por");
    @(negedge clk);
    rstn = 1'b1;

    // Two-product group: 3*5 + 7*9.
    step(1, 0, 4'd3, 4'd5); step(1, 0, 4'd7, 4'd9); idle(4);
    check_eq("t1_sum78", get_dout(0), 16'd78);

    // Back-to-back groups of four with no bubble.
    do_reset();
    repeat (4) step(1, 0, 4'd15, 4'd15);
    repeat (4) step(1, 0, 4'd1, 4'd2);
    idle(5);
    check_eq("t2_sum8", get_dout(1), 16'd8);

    // Signed extremes: (-8*-8)+(-8*7)=8, then 64+64=128.
    do_reset();
    step(1, 0, 4'd8, 4'd8); step(1, 0, 4'd8, 4'd7); idle(4);
    check_eq("t3_sum8", get_dout(2), 16'd8);
    step(1, 0, 4'd8, 4'd8); step(1, 0, 4'd8, 4'd8); idle(4);
    check_eq("t3_sum128", get_dout(2), 16'd128);

    // Gapped group of three.
    do_reset();
    step(1, 0, 4'd2, 4'd2); idle(5);
    step(1, 0, 4'd3, 4'd3); idle(2);
    step(1, 0, 4'd1, 4'd4); idle(4);
    check_eq("t4_sum17", get_dout(3), 16'd17);

    // clr with a same-cycle sample aborts the group.
    do_reset();
    step(1, 0, 4'd5, 4'd5); step(1, 1, 4'd9, 4'd9);
    step(1, 0, 4'd1, 4'd1); step(1, 0, 4'd2, 4'd2); idle(4);
    check_eq("t5_sum5", get_dout(0), 16'd5);

    // Reset while the group is half done, then a fresh group.
    do_reset();
    step(1, 0, 4'd3, 4'd3); step(1, 0, 4'd6, 4'd6); step(0, 0, 4'd0, 4'd0);
    do_reset();
    step(1, 0, 4'd4, 4'd4); step(1, 0, 4'd1, 4'd1); idle(4);
    check_eq("t6_sum17", get_dout(0), 16'd17);

    // Random stream with occasional clr and reset.
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(199);
      if (r < 2) do_reset();
      else step(r < 140, r >= 188, 4'($urandom), 4'($urandom));
    end
    idle(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
